// File: rtl/isp1362_bus_arbiter.sv
// Shares one ISP1362 bus between HC and DC Avalon-MM requesters with a timed CS_N/RD_N/WR_N cycle; ack after 1+SETUP+STROBE+HOLD cycles.
// Requesters stall on waitrequest until their access acks; default round-robin, ISP1362_DC_PRIORITY_EN makes DC win every tie.
module isp1362_bus_arbiter #(
    parameter int SETUP_CYC    = 1,
    parameter int STROBE_CYC   = 3,
    parameter int HOLD_CYC     = 1,
    parameter int RECOVERY_CYC = 4,
    parameter int CNT_W        = 4
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        hc_addr,
    input  logic        hc_read,
    input  logic        hc_write,
    input  logic [15:0] hc_writedata,
    output logic [15:0] hc_readdata,
    output logic        hc_waitrequest,
    output logic        hc_irq_n,
    input  logic        dc_addr,
    input  logic        dc_read,
    input  logic        dc_write,
    input  logic [15:0] dc_writedata,
    output logic [15:0] dc_readdata,
    output logic        dc_waitrequest,
    output logic        dc_irq_n,
    output logic [1:0]  USB_ADDR,
    output logic        USB_CS_N,
    output logic        USB_RD_N,
    output logic        USB_WR_N,
    output logic [15:0] USB_DATA_OUT,
    output logic        USB_DATA_OE,
    input  logic [15:0] USB_DATA_IN,
    input  logic        USB_INT0,
    input  logic        USB_INT1
);

    localparam logic [CNT_W-1:0] SETUP_LD    = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] STROBE_LD   = CNT_W'(STROBE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD     = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] RECOVERY_LD = CNT_W'(RECOVERY_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_RECOVER
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        hc_req, dc_req, accept, grant_dc, phase_done, strobe_last, bus_active_d;
    logic        sel_dc_q, sel_dc_d;
    logic        addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d, oe_q, oe_d;
    logic        hc_ack_q, hc_ack_d, dc_ack_q, dc_ack_d;
    logic [15:0] hc_rdata_q, dc_rdata_q;
    logic [1:0]  hc_irq_sync_q, dc_irq_sync_q;

    assign hc_req      = hc_read | hc_write;
    assign dc_req      = dc_read | dc_write;
    assign accept      = (state_q == S_IDLE) && (hc_req || dc_req);
    assign phase_done  = (cnt_q == CNT_W'(1));
    assign strobe_last = (state_q == S_STROBE) && phase_done;

`ifdef ISP1362_DC_PRIORITY_EN
    assign grant_dc = dc_req;
`else
    logic last_grant_q;  // 1 = DC was granted last

    assign grant_dc = (hc_req && dc_req) ? ~last_grant_q : dc_req;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            last_grant_q <= 1'b1;
        end else if (accept) begin
            last_grant_q <= grant_dc;
        end
    end
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - CNT_W'(1);
        unique case (state_q)
            S_IDLE: begin
                cnt_d = cnt_q;
                if (accept) begin
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            S_SETUP: if (phase_done) begin
                state_d = S_STROBE;
                cnt_d   = STROBE_LD;
            end
            S_STROBE: if (phase_done) begin
                state_d = S_HOLD;
                cnt_d   = HOLD_LD;
            end
            S_HOLD: if (phase_done) begin
                state_d = S_RECOVER;
                cnt_d   = RECOVERY_LD;
            end
            S_RECOVER: if (phase_done) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin controls are computed from the next state so the pads switch on the phase-entry edge.
    always_comb begin
        sel_dc_d = sel_dc_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        if (accept) begin
            sel_dc_d = grant_dc;
            addr_d   = grant_dc ? dc_addr  : hc_addr;
            wr_d     = grant_dc ? dc_write : hc_write;
            if (wr_d) begin
                wdata_d = grant_dc ? dc_writedata : hc_writedata;
            end
        end
        bus_active_d = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
        cs_n_d   = ~bus_active_d;
        rd_n_d   = ~((state_d == S_STROBE) && !wr_d);
        wr_n_d   = ~((state_d == S_STROBE) &&  wr_d);
        oe_d     = bus_active_d && wr_d;
        hc_ack_d = (state_q == S_HOLD) && (state_d == S_RECOVER) && !sel_dc_q;
        dc_ack_d = (state_q == S_HOLD) && (state_d == S_RECOVER) &&  sel_dc_q;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sel_dc_q      <= 1'b0;
            addr_q        <= 1'b0;
            wr_q          <= 1'b0;
            wdata_q       <= '0;
            cs_n_q        <= 1'b1;
            rd_n_q        <= 1'b1;
            wr_n_q        <= 1'b1;
            oe_q          <= 1'b0;
            hc_ack_q      <= 1'b0;
            dc_ack_q      <= 1'b0;
            hc_rdata_q    <= '0;
            dc_rdata_q    <= '0;
            hc_irq_sync_q <= 2'b11;
            dc_irq_sync_q <= 2'b11;
        end else begin
            sel_dc_q      <= sel_dc_d;
            addr_q        <= addr_d;
            wr_q          <= wr_d;
            wdata_q       <= wdata_d;
            cs_n_q        <= cs_n_d;
            rd_n_q        <= rd_n_d;
            wr_n_q        <= wr_n_d;
            oe_q          <= oe_d;
            hc_ack_q      <= hc_ack_d;
            dc_ack_q      <= dc_ack_d;
            hc_irq_sync_q <= {hc_irq_sync_q[0], USB_INT0};
            dc_irq_sync_q <= {dc_irq_sync_q[0], USB_INT1};
            if (strobe_last && !wr_q) begin
                if (sel_dc_q) begin
                    dc_rdata_q <= USB_DATA_IN;
                end else begin
                    hc_rdata_q <= USB_DATA_IN;
                end
            end
        end
    end

    assign hc_waitrequest = hc_req & ~hc_ack_q;
    assign dc_waitrequest = dc_req & ~dc_ack_q;
    assign hc_readdata    = hc_rdata_q;
    assign dc_readdata    = dc_rdata_q;
    assign hc_irq_n       = hc_irq_sync_q[1];
    assign dc_irq_n       = dc_irq_sync_q[1];
    assign USB_ADDR       = {sel_dc_q, addr_q};
    assign USB_CS_N       = cs_n_q;
    assign USB_RD_N       = rd_n_q;
    assign USB_WR_N       = wr_n_q;
    assign USB_DATA_OUT   = wdata_q;
    assign USB_DATA_OE    = oe_q;

endmodule
